// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus strobe/handshake FSM that feeds the UART transmitter's Tx_DATA/Tx_WR/Tx_BUSY port.
// Reports rejected pushes (overflow) and strobes the transmitter never acknowledged (tx_noack).
module uart_tx_feeder #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned ACK_TO     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          wr_data,
    input  logic                wr_en,
    input  logic                flush,
    input  logic                en,
    input  logic                err_clr,
    output logic                fifo_full,
    output logic                fifo_empty,
    output logic [DEPTH_LOG2:0] fifo_count,
    output logic                overflow,
    output logic                tx_noack,
    output logic [7:0]          Tx_DATA,
    output logic                Tx_WR,
    output logic                Tx_EN,
    input  logic                Tx_BUSY
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned TW    = $clog2(ACK_TO + 1);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT_HI, WAIT_LO} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            overflow_q, overflow_d;
    logic            noack_q, noack_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_wr_q, tx_wr_d;
    logic            tx_en_q, tx_en_d;
    logic [7:0]      mem_q [DEPTH];

    logic            push;
    logic            pop;
    logic            ovf_set;
    logic            noack_set;

    // Handshake FSM: pop in IDLE, one strobe cycle, then track the Tx_BUSY pulse.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        noack_set = 1'b0;
        case (state_q)
            IDLE: begin
                // flush wins over a pop in the same cycle, so the head byte is discarded, not sent
                if (tx_en_q && !empty_q && !Tx_BUSY && !flush) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = STROBE;
                end
            end
            STROBE: begin
                timer_d = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (Tx_BUSY) begin
                    state_d = WAIT_LO;
                end else if (timer_q == TW'(ACK_TO - 1)) begin
                    noack_set = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_LO: begin
                if (!Tx_BUSY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping and sticky error flags.
    always_comb begin
        push     = wr_en && !full_q && !flush;
        ovf_set  = wr_en && full_q && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        full_d     = (count_d == CW'(DEPTH));
        empty_d    = (count_d == '0);
        overflow_d = ovf_set   ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
        noack_d    = noack_set ? 1'b1 : (err_clr ? 1'b0 : noack_q);
        tx_wr_d    = (state_d == STROBE);
        tx_en_d    = en;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            noack_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_wr_q    <= 1'b0;
            tx_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            noack_q    <= noack_d;
            tx_data_q  <= tx_data_d;
            tx_wr_q    <= tx_wr_d;
            tx_en_q    <= tx_en_d;
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign tx_noack   = noack_q;
    assign Tx_DATA    = tx_data_q;
    assign Tx_WR      = tx_wr_q;
    assign Tx_EN      = tx_en_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: accepted bytes are queued in order, a monitor checks every strobe,
// and a simple transmitter model answers strobes with a Tx_BUSY pulse.
module tb_uart_tx_feeder;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;
    localparam int ACK_TO     = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [7:0]          wr_data;
    logic                wr_en;
    logic                flush;
    logic                en;
    logic                err_clr;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                overflow;
    logic                tx_noack;
    logic [7:0]          Tx_DATA;
    logic                Tx_WR;
    logic                Tx_EN;
    logic                Tx_BUSY;

    logic       busy_m      = 1'b0;
    logic       force_busy  = 1'b0;
    logic       noack_mode  = 1'b0;
    int         busy_dly    = 2;
    int         frame_len   = 100;

    int         cyc         = 0;
    int         n_chk       = 0;
    int         n_fail      = 0;
    int         strobe_cnt  = 0;
    int         last_strobe = -1;
    logic [7:0] exp_q [$];

    assign Tx_BUSY = busy_m | force_busy;

    uart_tx_feeder #(.DEPTH_LOG2(DEPTH_LOG2), .ACK_TO(ACK_TO)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
        .en(en), .err_clr(err_clr), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_count(fifo_count), .overflow(overflow), .tx_noack(tx_noack),
        .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR), .Tx_EN(Tx_EN), .Tx_BUSY(Tx_BUSY)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Bench-side acceptance rule: a push lands only if fewer than DEPTH bytes are waiting.
    task automatic push(input logic [7:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int budget, input string nm);
        int n;
        n = 0;
        while (strobe_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk(nm, 32'(strobe_cnt), 32'(target));
    endtask

    task automatic wait_quiet();
        int n;
        repeat (ACK_TO + 4) step();
        n = 0;
        while (busy_m && n < 1000) begin
            step();
            n++;
        end
        repeat (4) step();
    endtask

    // Transmitter model: Tx_BUSY rises busy_dly cycles after a strobe and stays up frame_len cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b1 && Tx_WR === 1'b1 && !noack_mode) begin
                repeat (busy_dly) @(posedge clk);
                #1 busy_m = 1'b1;
                repeat (frame_len) @(posedge clk);
                #1 busy_m = 1'b0;
            end
        end
    end

    // Monitor: every strobe must carry the oldest outstanding accepted byte.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b1 && Tx_WR === 1'b1) begin
                strobe_cnt++;
                last_strobe = cyc;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: Tx_DATA=%02h, expected no strobe (cycle %0d)", Tx_DATA, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_data", 32'(Tx_DATA), 32'(e));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        int base, n0, s0, k;
        rst = 1'b0; wr_data = 8'h00; wr_en = 1'b0; flush = 1'b0; en = 1'b0; err_clr = 1'b0;

        // Reset then idle
        repeat (3) step();
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_tx_wr", 32'(Tx_WR), 0);
        rst = 1'b1;
        repeat (4) step();
        chk("idle_tx_wr", 32'(Tx_WR), 0);
        chk("idle_tx_data", 32'(Tx_DATA), 0);
        chk("idle_empty", 32'(fifo_empty), 1);
        chk("idle_count", 32'(fifo_count), 0);
        chk("idle_full", 32'(fifo_full), 0);
        chk("idle_overflow", 32'(overflow), 0);
        chk("idle_noack", 32'(tx_noack), 0);
        chk("idle_tx_en", 32'(Tx_EN), 0);

        // Single byte, strobe latency N+2, no repeat strobe
        en = 1'b1;
        repeat (2) step();
        chk("tx_en_follows", 32'(Tx_EN), 1);
        base = strobe_cnt;
        n0 = cyc;
        push(8'hA5);
        wait_strobes(base + 1, 10, "single_strobe");
        chk("single_latency", 32'(last_strobe), 32'(n0 + 2));
        repeat (120) step();
        chk("single_no_repeat", 32'(strobe_cnt), 32'(base + 1));

        // Burst of 20 with the transmitter held busy: fill, overflow, drain in order
        frame_len = 5;
        force_busy = 1'b1;
        repeat (2) step();
        base = strobe_cnt;
        for (int i = 0; i < 20; i++) push(8'(i));
        chk("burst_count", 32'(fifo_count), 16);
        chk("burst_full", 32'(fifo_full), 1);
        chk("burst_empty", 32'(fifo_empty), 0);
        chk("burst_overflow", 32'(overflow), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("overflow_cleared", 32'(overflow), 0);
        force_busy = 1'b0;
        wait_strobes(base + 16, 1000, "burst_drain");
        wait_quiet();
        chk("burst_drained_count", 32'(fifo_count), 0);
        chk("burst_drained_empty", 32'(fifo_empty), 1);

        // Second pass of 16 exercises pointer wrap
        force_busy = 1'b1;
        repeat (2) step();
        base = strobe_cnt;
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        chk("wrap_full", 32'(fifo_full), 1);
        chk("wrap_no_overflow", 32'(overflow), 0);
        force_busy = 1'b0;
        wait_strobes(base + 16, 1000, "wrap_drain");
        wait_quiet();
        chk("wrap_drained_count", 32'(fifo_count), 0);

        // No-ack: flag rises ACK_TO cycles after WAIT_HI entry, next byte follows
        noack_mode = 1'b1;
        base = strobe_cnt;
        push(8'h5A);
        push(8'hC3);
        wait_strobes(base + 1, 10, "noack_first_strobe");
        s0 = last_strobe;
        while (cyc < s0 + ACK_TO) step();
        chk("noack_not_early", 32'(tx_noack), 0);
        step();
        chk("noack_set", 32'(tx_noack), 1);
        wait_strobes(base + 2, 10, "noack_next_strobe");
        chk("noack_next_timing", 32'(last_strobe), 32'(s0 + ACK_TO + 2));
        wait_quiet();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("noack_cleared", 32'(tx_noack), 0);
        noack_mode = 1'b0;

        // Enable dropped mid-frame, then flush with a simultaneous write
        frame_len = 60;
        force_busy = 1'b1;
        repeat (2) step();
        base = strobe_cnt;
        for (int i = 0; i < 4; i++) push(8'(8'h71 + i));
        force_busy = 1'b0;
        wait_strobes(base + 1, 10, "en_first_strobe");
        en = 1'b0;
        repeat (80) step();
        chk("en_low_no_strobe", 32'(strobe_cnt), 32'(base + 1));
        chk("en_low_count", 32'(fifo_count), 32'(exp_q.size()));
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        step();
        flush = 1'b0; wr_en = 1'b0;
        exp_q.delete();
        chk("flush_count", 32'(fifo_count), 0);
        chk("flush_empty", 32'(fifo_empty), 1);
        chk("flush_no_overflow", 32'(overflow), 0);
        chk("flush_tx_data_kept", 32'(Tx_DATA), 32'h71);
        en = 1'b1;
        repeat (10) step();
        chk("flush_no_strobe", 32'(strobe_cnt), 32'(base + 1));

        // Asynchronous reset pulse while waiting for Tx_BUSY to fall
        frame_len = 50;
        base = strobe_cnt;
        push(8'h11);
        wait_strobes(base + 1, 10, "rst_case_strobe");
        push(8'h22);
        push(8'h33);
        repeat (10) step();
        #3 rst = 1'b0;
        #1;
        chk("arst_tx_data", 32'(Tx_DATA), 0);
        chk("arst_tx_wr", 32'(Tx_WR), 0);
        chk("arst_tx_en", 32'(Tx_EN), 0);
        chk("arst_count", 32'(fifo_count), 0);
        chk("arst_empty", 32'(fifo_empty), 1);
        #2 rst = 1'b1;
        exp_q.delete();
        step();
        chk("arst_release_empty", 32'(fifo_empty), 1);
        wait_quiet();
        chk("arst_no_strobe", 32'(strobe_cnt), 32'(base + 1));

        // Randomized rounds: random bytes, gaps, busy delay and frame length
        for (int r = 0; r < 6; r++) begin
            frame_len = $urandom_range(3, 20);
            busy_dly  = $urandom_range(1, 4);
            base = strobe_cnt;
            k = $urandom_range(1, 16);
            for (int i = 0; i < k; i++) begin
                push(8'($urandom_range(0, 255)));
                repeat ($urandom_range(0, 3)) step();
            end
            wait_strobes(base + k, 3000, "rand_drain");
            wait_quiet();
            chk("rand_count", 32'(fifo_count), 0);
            chk("rand_overflow", 32'(overflow), 0);
            chk("rand_noack", 32'(tx_noack), 0);
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
